// File: rtl/cart_motion_controller.sv
// Per-cart motion integrator: turns direction/boost commands into a clamped (x,y) track
// position with heading, moving and wall flags, advancing once per move tick while racing.
module cart_motion_controller #(
  parameter int TICK_DIV   = 250000,
  parameter int STEP       = 1,
  parameter int BOOST_STEP = 3,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 629,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 469,
  parameter int START_X    = 40,
  parameter int START_Y    = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [2:0] op_code,
  input  logic       boost,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] heading,
  output logic       moving,
  output logic       move_tick,
  output logic       at_wall
);

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_SETTING   = 3'd1,
    GS_SYNCING   = 3'd2,
    GS_COUNTDOWN = 3'd3,
    GS_RACING    = 3'd4,
    GS_PAUSE     = 3'd5,
    GS_FINISH    = 3'd6
  } game_state_e;

  typedef enum logic [1:0] {
    HD_UP    = 2'd0,
    HD_DOWN  = 2'd1,
    HD_LEFT  = 2'd2,
    HD_RIGHT = 2'd3
  } heading_e;

  localparam logic [2:0] OP_UP    = 3'd1;
  localparam logic [2:0] OP_DOWN  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [9:0] X_LO    = 10'(X_MIN);
  localparam logic [9:0] X_HI    = 10'(X_MAX);
  localparam logic [9:0] Y_LO    = 10'(Y_MIN);
  localparam logic [9:0] Y_HI    = 10'(Y_MAX);
  localparam logic [9:0] X_START = 10'(START_X);
  localparam logic [9:0] Y_START = 10'(START_Y);

  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] BOOST_S = 12'(BOOST_STEP);

  // Saturate a widened signed coordinate into [lo,hi]; never wraps.
  function automatic logic [9:0] clamp10(input logic signed [11:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (v < $signed({2'b00, lo}))      return lo;
    else if (v > $signed({2'b00, hi})) return hi;
    else                               return v[9:0];
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0]       heading_q, heading_d;
  logic             moving_q, moving_d;
  logic             tick_q, tick_d;
  logic             at_wall_q, at_wall_d;

  logic signed [11:0] step_s, raw_s;
  logic               do_move, on_x;
  logic [9:0]         clamped;

  always_comb begin
    div_d     = div_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    heading_d = heading_q;
    moving_d  = moving_q;
    at_wall_d = at_wall_q;
    tick_d    = 1'b0;
    step_s    = boost ? BOOST_S : STEP_S;
    raw_s     = '0;
    do_move   = 1'b0;
    on_x      = 1'b0;
    clamped   = '0;

    case (op_code)
      OP_UP:    begin do_move = 1'b1; raw_s = $signed({2'b00, pos_y_q}) - step_s; end
      OP_DOWN:  begin do_move = 1'b1; raw_s = $signed({2'b00, pos_y_q}) + step_s; end
      OP_LEFT:  begin do_move = 1'b1; on_x = 1'b1; raw_s = $signed({2'b00, pos_x_q}) - step_s; end
      OP_RIGHT: begin do_move = 1'b1; on_x = 1'b1; raw_s = $signed({2'b00, pos_x_q}) + step_s; end
      default:  do_move = 1'b0;
    endcase
    clamped = on_x ? clamp10(raw_s, X_LO, X_HI) : clamp10(raw_s, Y_LO, Y_HI);

    case (state)
      GS_RACING: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          tick_d    = 1'b1;
          moving_d  = 1'b0;
          at_wall_d = 1'b0;
          if (do_move) begin
            at_wall_d = ($signed({2'b00, clamped}) != raw_s);
            if (on_x) begin
              pos_x_d  = clamped;
              moving_d = (clamped != pos_x_q);
            end else begin
              pos_y_d  = clamped;
              moving_d = (clamped != pos_y_q);
            end
            case (op_code)
              OP_UP:   heading_d = HD_UP;
              OP_DOWN: heading_d = HD_DOWN;
              OP_LEFT: heading_d = HD_LEFT;
              default: heading_d = HD_RIGHT;
            endcase
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GS_PAUSE: div_d = div_q;
      GS_IDLE, GS_SETTING, GS_SYNCING, GS_COUNTDOWN: begin
        div_d     = '0;
        pos_x_d   = X_START;
        pos_y_d   = Y_START;
        heading_d = HD_RIGHT;
        moving_d  = 1'b0;
        at_wall_d = 1'b0;
      end
      // FINISH and unused encodings hold position but restart the divider.
      default: div_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      pos_x_q   <= X_START;
      pos_y_q   <= Y_START;
      heading_q <= HD_RIGHT;
      moving_q  <= 1'b0;
      tick_q    <= 1'b0;
      at_wall_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      heading_q <= heading_d;
      moving_q  <= moving_d;
      tick_q    <= tick_d;
      at_wall_q <= at_wall_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign heading   = heading_q;
  assign moving    = moving_q;
  assign move_tick = tick_q;
  assign at_wall   = at_wall_q;

endmodule
